// File: rtl/conv3x3_tap_scheduler.sv
// 3x3 valid-convolution tap scheduler.
// This block walks output pixels, input channels and kernel taps, and issues feature and
// weight read addresses. It delays the control signals so they line up with memory data that
// arrives one cycle after the read. It also drives accumulator control and flags each
// finished output pixel.
module conv3x3_tap_scheduler #(
    parameter int unsigned IMG_W   = 16,
    parameter int unsigned IMG_H   = 16,
    parameter int unsigned CH      = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WADDR_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [WADDR_W-1:0] wt_addr,
    output logic [3:0]         tap_idx,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               out_valid,
    output logic [7:0]         out_row,
    output logic [7:0]         out_col
);

    localparam int unsigned OUT_W = IMG_W - 2;
    localparam int unsigned OUT_H = IMG_H - 2;
    localparam int unsigned FRAME = IMG_W * IMG_H;
    localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q;
    logic [1:0]        kx_q, ky_q, drain_q;
    logic [3:0]        tap_q;
    logic [CH_W-1:0]   ch_q;
    logic [7:0]        col_q, row_q;

    // Attributes of the read currently on the bus (issue stage -> data stage)
    logic [3:0]        rd_tap_q;
    logic              rd_first_q, rd_last_q;
    logic [7:0]        rd_row_q, rd_col_q;
    // Attributes of the data being accumulated (data stage -> result stage)
    logic              acc_last_q;
    logic [7:0]        acc_row_q, acc_col_q;

    logic              issue, tap_last, ch_last, col_last, row_last;
    logic [ADDR_W-1:0] addr_next;
    logic [WADDR_W-1:0] waddr_next;

    // Read issue decision, wrap flags and address generation from the current counters
    always_comb begin
        issue      = (state_q == StRun) && !hold;
        tap_last   = (tap_q == 4'd8);
        ch_last    = (ch_q == CH_W'(CH - 1));
        col_last   = (col_q == 8'(OUT_W - 1));
        row_last   = (row_q == 8'(OUT_H - 1));
        addr_next  = ADDR_W'(32'(ch_q) * FRAME + (32'(row_q) + 32'(ky_q)) * IMG_W
                             + 32'(col_q) + 32'(kx_q));
        waddr_next = WADDR_W'(32'(ch_q) * 9 + 32'(tap_q));
    end

    // FSM, counters and the two-stage delay pipeline, all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            kx_q       <= '0;
            ky_q       <= '0;
            tap_q      <= '0;
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            rd_tap_q   <= '0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            acc_last_q <= 1'b0;
            acc_row_q  <= '0;
            acc_col_q  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wt_addr    <= '0;
            tap_idx    <= '0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= issue;

            if (issue) begin
                rd_addr    <= addr_next;
                wt_addr    <= waddr_next;
                rd_tap_q   <= tap_q;
                rd_first_q <= (ch_q == '0) && (tap_q == 4'd0);
                rd_last_q  <= ch_last && tap_last;
                rd_row_q   <= row_q;
                rd_col_q   <= col_q;
            end

            // Data returns one cycle after rd_en
            acc_en     <= rd_en;
            acc_clr    <= rd_en && rd_first_q;
            tap_idx    <= rd_tap_q;
            acc_last_q <= rd_en && rd_last_q;
            acc_row_q  <= rd_row_q;
            acc_col_q  <= rd_col_q;

            // Pixel is complete once its last tap has been accumulated
            out_valid <= acc_last_q;
            if (acc_last_q) begin
                out_row <= acc_row_q;
                out_col <= acc_col_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        kx_q    <= '0;
                        ky_q    <= '0;
                        tap_q   <= '0;
                        ch_q    <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                StRun: begin
                    if (!hold) begin
                        if (tap_last) begin
                            tap_q <= '0;
                            kx_q  <= '0;
                            ky_q  <= '0;
                            if (ch_last) begin
                                ch_q <= '0;
                                if (col_last) begin
                                    col_q <= '0;
                                    row_q <= row_q + 8'd1;
                                    if (row_last) begin
                                        state_q <= StDrain;
                                        drain_q <= '0;
                                    end
                                end else begin
                                    col_q <= col_q + 8'd1;
                                end
                            end else begin
                                ch_q <= ch_q + CH_W'(1);
                            end
                        end else begin
                            tap_q <= tap_q + 4'd1;
                            if (kx_q == 2'd2) begin
                                kx_q <= '0;
                                ky_q <= ky_q + 2'd1;
                            end else begin
                                kx_q <= kx_q + 2'd1;
                            end
                        end
                    end
                end
                StDrain: begin
                    // Wait for the last read's acc_en and out_valid to pass, then signal done
                    drain_q <= drain_q + 2'd1;
                    if (drain_q == 2'd2) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_tap_scheduler.sv
// Directed bench for conv3x3_tap_scheduler: three instances (4x4/CH1, 4x4/CH2, 3x3/CH1).
module tb_conv3x3_tap_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_r[3];
    logic       hold_r[3];
    logic       busy_w[3], done_w[3], rd_en_w[3], acc_clr_w[3], acc_en_w[3], out_valid_w[3];
    logic [9:0] rd_addr_w[3];
    logic [5:0] wt_addr_w[3];
    logic [3:0] tap_idx_w[3];
    logic [7:0] out_row_w[3], out_col_w[3];

    conv3x3_tap_scheduler #(.IMG_W(4), .IMG_H(4), .CH(1), .ADDR_W(10), .WADDR_W(6)) dut_a (
        .clk(clk), .reset(reset), .start(start_r[0]), .hold(hold_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]),
        .wt_addr(wt_addr_w[0]), .tap_idx(tap_idx_w[0]), .acc_clr(acc_clr_w[0]),
        .acc_en(acc_en_w[0]), .out_valid(out_valid_w[0]), .out_row(out_row_w[0]),
        .out_col(out_col_w[0])
    );

    conv3x3_tap_scheduler #(.IMG_W(4), .IMG_H(4), .CH(2), .ADDR_W(10), .WADDR_W(6)) dut_b (
        .clk(clk), .reset(reset), .start(start_r[1]), .hold(hold_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]),
        .wt_addr(wt_addr_w[1]), .tap_idx(tap_idx_w[1]), .acc_clr(acc_clr_w[1]),
        .acc_en(acc_en_w[1]), .out_valid(out_valid_w[1]), .out_row(out_row_w[1]),
        .out_col(out_col_w[1])
    );

    conv3x3_tap_scheduler #(.IMG_W(3), .IMG_H(3), .CH(1), .ADDR_W(10), .WADDR_W(6)) dut_c (
        .clk(clk), .reset(reset), .start(start_r[2]), .hold(hold_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .rd_en(rd_en_w[2]), .rd_addr(rd_addr_w[2]),
        .wt_addr(wt_addr_w[2]), .tap_idx(tap_idx_w[2]), .acc_clr(acc_clr_w[2]),
        .acc_en(acc_en_w[2]), .out_valid(out_valid_w[2]), .out_row(out_row_w[2]),
        .out_col(out_col_w[2])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run observations
    int          reads, done_cnt, done_cycle, busy_at_done, follow_err, tap_err, clr_cnt;
    int          acc_total, acc_since, pix_min, pix_max, bad_after_abort;
    logic        prev_rd;
    logic [9:0]  addr_q[$];
    logic [5:0]  wt_q[$];
    logic [15:0] ov_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        return {22'b0, busy_w[d], done_w[d], rd_en_w[d], rd_addr_w[d], wt_addr_w[d],
                tap_idx_w[d], acc_clr_w[d], acc_en_w[d], out_valid_w[d],
                out_row_w[d], out_col_w[d]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a layer on instance d and observe it until done (or a 400-cycle bound)
    task automatic run(input int d, input bit use_hold, input int start_at, input int abort_at);
        bit finished;
        reads = 0; done_cnt = 0; done_cycle = -1; busy_at_done = -1; follow_err = 0;
        tap_err = 0; clr_cnt = 0; acc_total = 0; acc_since = 0; pix_min = 1000; pix_max = 0;
        bad_after_abort = 0; prev_rd = 1'b0; finished = 1'b0;
        addr_q.delete(); wt_q.delete(); ov_q.delete();
        start_r[d] = 1'b1;
        tick;
        start_r[d] = 1'b0;
        for (int c = 1; c <= 400 && !finished; c++) begin
            tick;
            if (acc_en_w[d] !== prev_rd) follow_err++;
            if (acc_en_w[d] === 1'b1) begin
                if (tap_idx_w[d] !== 4'(acc_total % 9)) tap_err++;
                acc_total++;
            end
            if (acc_clr_w[d] === 1'b1) clr_cnt++;
            if (out_valid_w[d] === 1'b1) begin
                ov_q.push_back({out_row_w[d], out_col_w[d]});
                if (acc_since < pix_min) pix_min = acc_since;
                if (acc_since > pix_max) pix_max = acc_since;
                acc_since = (acc_en_w[d] === 1'b1) ? 1 : 0;
            end else if (acc_en_w[d] === 1'b1) begin
                acc_since++;
            end
            prev_rd = rd_en_w[d];
            if (rd_en_w[d] === 1'b1) begin
                reads++;
                addr_q.push_back(rd_addr_w[d]);
                wt_q.push_back(wt_addr_w[d]);
            end
            if (done_w[d] === 1'b1) begin
                done_cnt++;
                done_cycle   = c;
                busy_at_done = int'(busy_w[d]);
                finished     = 1'b1;
            end
            hold_r[d]  = use_hold ? 1'($urandom_range(0, 1)) : 1'b0;
            start_r[d] = (c == start_at);
            if (abort_at > 0 && reads == abort_at) begin
                reset = 1'b0;
                #1;
                check("T5 outputs at reset", outs(d), 64'd0);
                tick;
                check("T5 outputs next cycle", outs(d), 64'd0);
                reset = 1'b1;
                for (int k = 0; k < 12; k++) begin
                    tick;
                    if (out_valid_w[d] !== 1'b0 || done_w[d] !== 1'b0) bad_after_abort++;
                end
                finished = 1'b1;
            end
        end
        hold_r[d]  = 1'b0;
        start_r[d] = 1'b0;
    endtask

    // Reference nested-loop walk of the layer, compared against the captured reads and pixels
    task automatic check_model(input string tag, input int w, input int h, input int chn);
        int k = 0;
        int err = 0;
        int perr = 0;
        int p = 0;
        for (int r = 0; r < h - 2; r++) begin
            for (int c = 0; c < w - 2; c++) begin
                for (int ch = 0; ch < chn; ch++) begin
                    for (int ky = 0; ky < 3; ky++) begin
                        for (int kx = 0; kx < 3; kx++) begin
                            if (k >= addr_q.size()) err++;
                            else if (addr_q[k] !== 10'(ch * w * h + (r + ky) * w + c + kx) ||
                                     wt_q[k] !== 6'(ch * 9 + ky * 3 + kx)) err++;
                            k++;
                        end
                    end
                end
                if (p >= ov_q.size() || ov_q[p] !== {8'(r), 8'(c)}) perr++;
                p++;
            end
        end
        check({tag, " address sequence"}, 64'(err), 64'd0);
        check({tag, " read count"}, 64'(addr_q.size()), 64'(k));
        check({tag, " pixel sequence"}, 64'(perr), 64'd0);
        check({tag, " out_valid count"}, 64'(ov_q.size()), 64'(p));
    endtask

    logic [9:0] t1_addr[9];
    logic [9:0] t2_addr[9];

    initial begin
        t1_addr = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd5, 10'd6, 10'd8, 10'd9, 10'd10};
        t2_addr = '{10'd16, 10'd17, 10'd18, 10'd20, 10'd21, 10'd22, 10'd24, 10'd25, 10'd26};
        for (int d = 0; d < 3; d++) begin
            start_r[d] = 1'b0;
            hold_r[d]  = 1'b0;
        end
        reset = 1'b0;
        repeat (3) tick;
        for (int d = 0; d < 3; d++) check($sformatf("reset outputs dut%0d", d), outs(d), 64'd0);
        reset = 1'b1;
        tick;

        // T1: 4x4, CH=1, no hold
        run(0, 1'b0, 0, 0);
        check("T1 reads", 64'(reads), 64'd36);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("T1 rd_addr[%0d]", i), 64'(addr_q[i]), 64'(t1_addr[i]));
            check($sformatf("T1 wt_addr[%0d]", i), 64'(wt_q[i]), 64'(i));
        end
        check_model("T1", 4, 4, 1);
        check("T1 done cycle", 64'(done_cycle), 64'd39);
        check("T1 busy at done", 64'(busy_at_done), 64'd0);
        check("T1 acc_en follows rd_en", 64'(follow_err), 64'd0);
        check("T1 tap_idx order", 64'(tap_err), 64'd0);
        check("T1 acc_clr count", 64'(clr_cnt), 64'd4);
        tick;
        check("T1 done one cycle", 64'(done_w[0]), 64'd0);
        check("T1 busy after done", 64'(busy_w[0]), 64'd0);

        // T2: 4x4, CH=2
        run(1, 1'b0, 0, 0);
        check("T2 reads", 64'(reads), 64'd72);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("T2 rd_addr[%0d]", 9 + i), 64'(addr_q[9 + i]), 64'(t2_addr[i]));
            check($sformatf("T2 wt_addr[%0d]", 9 + i), 64'(wt_q[9 + i]), 64'(9 + i));
        end
        check_model("T2", 4, 4, 2);
        check("T2 acc_clr per pixel", 64'(clr_cnt), 64'd4);
        check("T2 min acc_en per pixel", 64'(pix_min), 64'd18);
        check("T2 max acc_en per pixel", 64'(pix_max), 64'd18);
        check("T2 tap_idx order", 64'(tap_err), 64'd0);
        check("T2 done cycle", 64'(done_cycle), 64'd75);

        // T3: random hold
        run(0, 1'b1, 0, 0);
        check_model("T3", 4, 4, 1);
        check("T3 acc_en follows rd_en", 64'(follow_err), 64'd0);
        check("T3 tap_idx order", 64'(tap_err), 64'd0);
        check("T3 done count", 64'(done_cnt), 64'd1);
        check("T3 acc_clr count", 64'(clr_cnt), 64'd4);

        // T4: start pulsed mid-run is ignored, then back-to-back layer
        run(0, 1'b0, 10, 0);
        check_model("T4", 4, 4, 1);
        check("T4 done cycle", 64'(done_cycle), 64'd39);
        run(0, 1'b0, 0, 0);
        check_model("T4 restart", 4, 4, 1);
        check("T4 restart first addr", 64'(addr_q[0]), 64'd0);
        check("T4 restart done cycle", 64'(done_cycle), 64'd39);

        // T5: reset at read 20 aborts, then a fresh layer matches T1
        run(0, 1'b0, 0, 20);
        check("T5 no out_valid/done after reset", 64'(bad_after_abort), 64'd0);
        check("T5 no done", 64'(done_cnt), 64'd0);
        run(0, 1'b0, 0, 0);
        check_model("T5 rerun", 4, 4, 1);
        check("T5 rerun done cycle", 64'(done_cycle), 64'd39);

        // T6: 3x3 boundary
        run(2, 1'b0, 0, 0);
        check("T6 reads", 64'(reads), 64'd9);
        check_model("T6", 3, 3, 1);
        check("T6 done count", 64'(done_cnt), 64'd1);
        check("T6 done cycle", 64'(done_cycle), 64'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
